t20_match_ctrl: RTL
===================

# t20_match_ctrl

Match-state controller for the T20 cricket project. It consumes one scored delivery per `ball_valid` pulse and tracks runs, wickets, balls and overs across two innings. It computes the target and decides the result. It drives `game_over`, which is the enable input of the downstream rainbow LED celebration stage, and holds it high until a new match starts.

## Interface
- `OVERS`, 20, overs per innings (1..31)
- `BALLS_PER_OVER`, 6, legal deliveries per over (1..7)
- `MAX_WICKETS`, 10, wickets that end an innings (1..15)
- `clk`  input  1  system clock; all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  single-cycle pulse: begin match / begin innings 2 / restart after result
- `ball_valid`  input  1  single-cycle pulse: one delivery is presented on the `ball_*` lines
- `ball_runs`  input  3  runs off the delivery; values 7 are clamped to 6
- `ball_wicket`  input  1  delivery takes a wicket
- `ball_extra`  input  1  wide/no-ball: +1 penalty run, not a legal ball
- `runs`  output  9  current innings runs, saturating at 511
- `wickets`  output  4  current innings wickets
- `overs`  output  5  completed overs, current innings
- `balls`  output  3  legal balls in current over (0..BALLS_PER_OVER-1)
- `innings`  output  1  0 = first innings, 1 = second innings
- `target`  output  9  first-innings runs + 1; 0 before innings 2
- `game_over`  output  1  high in DONE state; feeds the celebration LEDs
- `winner`  output  2  00 none, 01 batting-first team, 10 chasing team, 11 tie

## Operation
- States: IDLE, INN1, BREAK, INN2, DONE. Reset sets IDLE and every output to 0.
- IDLE: on `start`, clear the counters and go to INN1 (`innings`=0).
- INN1/INN2 on `ball_valid`:
  - runs += clamp(`ball_runs`) + (`ball_extra` ? 1 : 0), saturating at 511.
  - If `ball_extra`=0: balls += 1. When balls reaches BALLS_PER_OVER, balls wraps to 0 and overs += 1.
  - If `ball_extra`=0 and `ball_wicket`=1: wickets += 1. A wicket on an extra is ignored.
- INN1 ends after the updating ball when wickets == MAX_WICKETS or overs == OVERS:
  - target <= final runs + 1, saturating at 511.
  - Go to BREAK. `runs`, `wickets`, `overs` and `balls` keep their innings-1 values.
- BREAK: on `start`, clear runs/wickets/overs/balls, set `innings`=1 and go to INN2.
- INN2 ends after the updating ball, with this priority:
  - runs >= target: winner=10 (win on the ball, even if that ball was also the last ball or the last wicket).
  - Otherwise, if wickets == MAX_WICKETS or overs == OVERS: winner=11 if runs == target-1, else 01.
  - Either way, go to DONE.
- DONE: `game_over`=1. Counters, `target` and `winner` are frozen. `ball_valid` is ignored. On `start`, behave as IDLE+start (clear everything, go to INN1, `game_over` drops).
- `start` is ignored in INN1 and INN2. `ball_valid` is ignored in IDLE, BREAK and DONE.
- If `start` and `ball_valid` arrive in the same cycle, the state decides which is used; the other is ignored.

## Timing
- Inputs are sampled on the rising edge where `ball_valid`/`start` is high. Counters reflect the ball 1 cycle later.
- The state transition and the registered `target`/`winner`/`game_over` take effect on the same edge as the ball that ends the innings, so they are visible 1 cycle after the `ball_valid` pulse.
- Back-to-back `ball_valid` pulses in consecutive cycles are all accepted; there are no bubbles.
- `rst_n` low at any time, including mid-innings or in DONE: all outputs go to 0 immediately and the state goes to IDLE. The first edge after `rst_n` rises takes effect normally.
- All outputs are registered; none is combinational from the inputs.

## Test plan
- Reset mid-INN2 with runs=37 → next sample shows all outputs 0 and state IDLE; a following `ball_valid` is ignored.
- OVERS=1, BALLS=6: `start`, then 6 legal 1-run balls plus 1 wide (runs=0) → after the 6th legal ball: runs=7, overs=1, balls=0, BREAK, target=8.
- INN2 (target=8): 1 ball with runs=6, then a wide with runs=1 → runs=8, `winner`=10 and `game_over`=1 one cycle after the second pulse; further balls leave runs at 8.
- MAX_WICKETS=2, target=8: a wicket ball with runs=0, then a ball with runs=6 and a wicket → runs=6 (< 7), `winner`=01. Repeat so that runs=7 at the final wicket → `winner`=11.
- `ball_runs`=7 with no extra → runs += 6. `ball_wicket`=1 with `ball_extra`=1 → wickets unchanged, balls unchanged, runs += 1.
- In DONE, pulse `start` → `game_over` is 0 the next cycle, `innings`=0, target=0, winner=00. In INN1, `start` together with `ball_valid` → the ball is counted and `start` is ignored.

Source files
------------

// File: rtl/t20_match_ctrl_if.sv
// Delivery/start inputs and scoreboard outputs of the T20 match controller.
// The bench drives through master; the controller attaches as slave.
interface t20_match_ctrl_if;
  logic       start;
  logic       ball_valid;
  logic [2:0] ball_runs;
  logic       ball_wicket;
  logic       ball_extra;
  logic [8:0] runs;
  logic [3:0] wickets;
  logic [4:0] overs;
  logic [2:0] balls;
  logic       innings;
  logic [8:0] target;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output start, ball_valid, ball_runs, ball_wicket, ball_extra,
    input  runs, wickets, overs, balls, innings, target, game_over, winner
  );

  modport slave (
    input  start, ball_valid, ball_runs, ball_wicket, ball_extra,
    output runs, wickets, overs, balls, innings, target, game_over, winner
  );
endinterface

// File: rtl/t20_match_ctrl.sv
// Two-innings T20 match state controller: counts runs/wickets/balls/overs,
// sets the chase target and decides the result that enables the LED stage.
module t20_match_ctrl #(
  parameter int OVERS          = 20,
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_WICKETS    = 10
) (
  input logic            clk,
  input logic            rst_n,
  t20_match_ctrl_if.slave bus
);

  localparam logic [4:0] OVERS_L = 5'(OVERS);
  localparam logic [3:0] BPO_L   = 4'(BALLS_PER_OVER);
  localparam logic [3:0] MW_L    = 4'(MAX_WICKETS);
  localparam logic [8:0] RUNS_MAX = 9'd511;

  typedef enum logic [2:0] {IDLE, INN1, BREAK, INN2, DONE} state_t;

  state_t     state_reg, state_next;
  logic [8:0] runs_reg, runs_next;
  logic [3:0] wickets_reg, wickets_next;
  logic [4:0] overs_reg, overs_next;
  logic [2:0] balls_reg, balls_next;
  logic       innings_reg, innings_next;
  logic [8:0] target_reg, target_next;
  logic       game_over_reg, game_over_next;
  logic [1:0] winner_reg, winner_next;

  // Counter values as they would stand after the presented delivery.
  logic [2:0] clamped_runs;
  logic [9:0] run_sum;
  logic [8:0] ball_runs_sat;
  logic [3:0] ball_wickets;
  logic [3:0] balls_inc;
  logic [2:0] ball_balls;
  logic [4:0] ball_overs;
  logic       innings_end;
  logic [8:0] target_calc;

  assign clamped_runs  = (bus.ball_runs == 3'd7) ? 3'd6 : bus.ball_runs;
  assign run_sum       = {1'b0, runs_reg} + 10'(clamped_runs) + 10'(bus.ball_extra);
  assign ball_runs_sat = run_sum[9] ? RUNS_MAX : run_sum[8:0];
  assign ball_wickets  = (!bus.ball_extra && bus.ball_wicket) ? wickets_reg + 4'd1 : wickets_reg;
  assign balls_inc     = {1'b0, balls_reg} + 4'd1;

  always_comb begin
    ball_balls = balls_reg;
    ball_overs = overs_reg;
    if (!bus.ball_extra) begin
      if (balls_inc == BPO_L) begin
        ball_balls = 3'd0;
        ball_overs = overs_reg + 5'd1;
      end else begin
        ball_balls = balls_inc[2:0];
      end
    end
  end

  assign innings_end = (ball_wickets == MW_L) || (ball_overs == OVERS_L);
  assign target_calc = (ball_runs_sat == RUNS_MAX) ? RUNS_MAX : ball_runs_sat + 9'd1;

  always_comb begin
    state_next     = state_reg;
    runs_next      = runs_reg;
    wickets_next   = wickets_reg;
    overs_next     = overs_reg;
    balls_next     = balls_reg;
    innings_next   = innings_reg;
    target_next    = target_reg;
    game_over_next = game_over_reg;
    winner_next    = winner_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next     = INN1;
          runs_next      = '0;
          wickets_next   = '0;
          overs_next     = '0;
          balls_next     = '0;
          innings_next   = 1'b0;
          target_next    = '0;
          game_over_next = 1'b0;
          winner_next    = 2'b00;
        end
      end
      BREAK: begin
        if (bus.start) begin
          state_next   = INN2;
          runs_next    = '0;
          wickets_next = '0;
          overs_next   = '0;
          balls_next   = '0;
          innings_next = 1'b1;
        end
      end
      INN1, INN2: begin
        if (bus.ball_valid) begin
          runs_next    = ball_runs_sat;
          wickets_next = ball_wickets;
          overs_next   = ball_overs;
          balls_next   = ball_balls;
          if (state_reg == INN1) begin
            if (innings_end) begin
              target_next = target_calc;
              state_next  = BREAK;
            end
          end else if (ball_runs_sat >= target_reg) begin
            // A winning ball beats an all-out or overs-complete on the same delivery.
            winner_next    = 2'b10;
            game_over_next = 1'b1;
            state_next     = DONE;
          end else if (innings_end) begin
            winner_next    = (ball_runs_sat == target_reg - 9'd1) ? 2'b11 : 2'b01;
            game_over_next = 1'b1;
            state_next     = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      runs_reg      <= '0;
      wickets_reg   <= '0;
      overs_reg     <= '0;
      balls_reg     <= '0;
      innings_reg   <= 1'b0;
      target_reg    <= '0;
      game_over_reg <= 1'b0;
      winner_reg    <= 2'b00;
    end else begin
      state_reg     <= state_next;
      runs_reg      <= runs_next;
      wickets_reg   <= wickets_next;
      overs_reg     <= overs_next;
      balls_reg     <= balls_next;
      innings_reg   <= innings_next;
      target_reg    <= target_next;
      game_over_reg <= game_over_next;
      winner_reg    <= winner_next;
    end
  end

  assign bus.runs      = runs_reg;
  assign bus.wickets   = wickets_reg;
  assign bus.overs     = overs_reg;
  assign bus.balls     = balls_reg;
  assign bus.innings   = innings_reg;
  assign bus.target    = target_reg;
  assign bus.game_over = game_over_reg;
  assign bus.winner    = winner_reg;

endmodule
